// File: rtl/pu_riscv_htif_pkg.sv
// Shared HTIF definitions: host handshake FSM states and default CSR addresses.
// Both the core-side responder and the host simulation model use them.
package pu_riscv_htif_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } htif_state_t;

  localparam logic [11:0] DEFAULT_TOHOST_ADDR   = 12'h780;
  localparam logic [11:0] DEFAULT_FROMHOST_ADDR = 12'h781;

endpackage

// File: rtl/pu_riscv_htif_csr.sv
// HTIF core-side responder: owns tohost/fromhost, serves single-cycle CPU CSR
// accesses and the host req/ack handshake.
module pu_riscv_htif_csr
  import pu_riscv_htif_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [11:0] TOHOST_ADDR   = DEFAULT_TOHOST_ADDR,
  parameter logic [11:0] FROMHOST_ADDR = DEFAULT_FROMHOST_ADDR
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            host_csr_req,
  output logic            host_csr_ack,
  input  logic            host_csr_we,
  output logic [XLEN-1:0] host_csr_tohost,
  input  logic [XLEN-1:0] host_csr_fromhost,
  input  logic            csr_req,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic            fromhost_irq
);

  htif_state_t     state, state_nxt;
  logic            we_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] tohost_q, tohost_nxt;
  logic [XLEN-1:0] fromhost_q, fromhost_nxt;
  logic            ack_q;
  logic            irq_q;
  logic            hit_to, hit_from, cpu_wr, exec_rd, exec_wr;

  assign hit_to   = (csr_addr == TOHOST_ADDR);
  assign hit_from = (csr_addr == FROMHOST_ADDR);
  assign csr_hit  = csr_req && (hit_to || hit_from);
  assign cpu_wr   = csr_req && csr_we;
  assign exec_rd  = (state == EXEC) && !we_q;
  assign exec_wr  = (state == EXEC) && we_q;

  assign csr_rdata       = hit_to ? tohost_q : (hit_from ? fromhost_q : '0);
  assign host_csr_tohost = tohost_q;
  assign host_csr_ack    = ack_q;
  assign fromhost_irq    = irq_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host_csr_req) state_nxt = EXEC;
      EXEC:    state_nxt = ACK;
      ACK:     state_nxt = RELEASE;
      RELEASE: if (!host_csr_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On a same-cycle collision the CPU keeps a freshly posted tohost message,
  // while the host's fromhost write overrides the CPU's.
  always_comb begin
    tohost_nxt   = tohost_q;
    fromhost_nxt = fromhost_q;
    if (exec_rd) tohost_nxt = '0;
    if (exec_wr) fromhost_nxt = data_q;
    if (cpu_wr && hit_to) tohost_nxt = csr_wdata;
    if (cpu_wr && hit_from && !exec_wr) fromhost_nxt = csr_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      data_q     <= '0;
      tohost_q   <= '0;
      fromhost_q <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && host_csr_req) begin
        we_q   <= host_csr_we;
        data_q <= host_csr_fromhost;
      end
      tohost_q   <= tohost_nxt;
      fromhost_q <= fromhost_nxt;
      ack_q      <= (state == EXEC);
      irq_q      <= (fromhost_nxt != '0);
    end
  end

endmodule

// File: tb/tb_pu_riscv_htif_csr.sv
// Directed bench for pu_riscv_htif_csr: CPU CSR port, host handshake,
// collisions, reset abort and address misses.
module tb_pu_riscv_htif_csr;

  logic        clk;
  logic        rstn;
  logic        host_csr_req;
  logic        host_csr_ack;
  logic        host_csr_we;
  logic [31:0] host_csr_tohost;
  logic [31:0] host_csr_fromhost;
  logic        csr_req;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        fromhost_irq;

  int compared = 0;
  int mismatched = 0;
  int ack_count;

  pu_riscv_htif_csr dut (
    .clk               (clk),
    .rstn              (rstn),
    .host_csr_req      (host_csr_req),
    .host_csr_ack      (host_csr_ack),
    .host_csr_we       (host_csr_we),
    .host_csr_tohost   (host_csr_tohost),
    .host_csr_fromhost (host_csr_fromhost),
    .csr_req           (csr_req),
    .csr_we            (csr_we),
    .csr_addr          (csr_addr),
    .csr_wdata         (csr_wdata),
    .csr_rdata         (csr_rdata),
    .csr_hit           (csr_hit),
    .fromhost_irq      (fromhost_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic hreq, input logic hwe, input logic [31:0] hdata,
                               input logic creq, input logic cwe, input logic [11:0] caddr,
                               input logic [31:0] cwdata);
    host_csr_req      = hreq;
    host_csr_we       = hwe;
    host_csr_fromhost = hdata;
    csr_req           = creq;
    csr_we            = cwe;
    csr_addr          = caddr;
    csr_wdata         = cwdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h000, 32'h0);
    tick();
    tick();
    checkOutput("reset_ack", host_csr_ack, 0);
    checkOutput("reset_tohost", host_csr_tohost, 0);
    checkOutput("reset_irq", fromhost_irq, 0);
    rstn = 1'b1;
    tick();

    // Load both registers, then reset in the middle of a host write.
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h780, 32'h11);
    checkOutput("cpu_wr_hit", csr_hit, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h781, 32'h5);
    checkOutput("tohost_after_cpu_wr", host_csr_tohost, 32'h11);
    tick();
    applyStimulus(1, 1, 32'h9, 0, 0, 12'h781, 32'h0);
    checkOutput("irq_after_cpu_wr", fromhost_irq, 1);
    checkOutput("rdata_fromhost_5", csr_rdata, 32'h5);
    tick();
    checkOutput("exec_no_ack", host_csr_ack, 0);
    rstn = 1'b0;
    #1;
    checkOutput("rst_mid_tohost", host_csr_tohost, 0);
    checkOutput("rst_mid_fromhost", csr_rdata, 0);
    checkOutput("rst_mid_irq", fromhost_irq, 0);
    tick();
    checkOutput("rst_hold_ack1", host_csr_ack, 0);
    tick();
    checkOutput("rst_hold_ack2", host_csr_ack, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    rstn = 1'b1;
    tick();
    checkOutput("rst_rel_ack1", host_csr_ack, 0);
    tick();
    checkOutput("rst_rel_ack2", host_csr_ack, 0);
    checkOutput("rst_rel_fromhost", csr_rdata, 0);
    checkOutput("rst_rel_tohost", host_csr_tohost, 0);

    // CPU posts tohost=1, host consumes it.
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h780, 32'h1);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 12'h780, 32'h0);
    checkOutput("tohost_eot", host_csr_tohost, 32'h1);
    tick();
    checkOutput("rd_exec_ack", host_csr_ack, 0);
    checkOutput("rd_exec_tohost", host_csr_tohost, 32'h1);
    tick();
    checkOutput("rd_ack", host_csr_ack, 1);
    checkOutput("rd_consumed", host_csr_tohost, 0);
    tick();
    checkOutput("rd_ack_drop", host_csr_ack, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h780, 32'h0);
    tick();

    // Host writes fromhost=A5; data changes after latch must not matter.
    applyStimulus(1, 1, 32'hA5, 0, 0, 12'h781, 32'h0);
    tick();
    applyStimulus(1, 1, 32'hDEAD, 0, 0, 12'h781, 32'h0);
    checkOutput("wr_exec_ack", host_csr_ack, 0);
    tick();
    checkOutput("wr_ack", host_csr_ack, 1);
    checkOutput("wr_fromhost", csr_rdata, 32'hA5);
    checkOutput("wr_irq", fromhost_irq, 1);
    tick();
    checkOutput("wr_ack_pulse", host_csr_ack, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h781, 32'h0);
    checkOutput("irq_before_clear", fromhost_irq, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    checkOutput("irq_cleared", fromhost_irq, 0);
    checkOutput("fromhost_cleared", csr_rdata, 0);

    // Collision: CPU posts tohost=3 during the EXEC of a host read.
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h780, 32'h7);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 12'h780, 32'h0);
    tick();
    applyStimulus(1, 0, 32'h0, 1, 1, 12'h780, 32'h3);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h780, 32'h0);
    checkOutput("col_rd_ack", host_csr_ack, 1);
    checkOutput("col_tohost_cpu_wins", host_csr_tohost, 32'h3);
    tick();
    tick();

    // Collision: CPU fromhost=5 versus host fromhost=7.
    applyStimulus(1, 1, 32'h7, 0, 0, 12'h781, 32'h0);
    tick();
    applyStimulus(1, 1, 32'h7, 1, 1, 12'h781, 32'h5);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    checkOutput("col_fromhost_host_wins", csr_rdata, 32'h7);
    checkOutput("col_irq", fromhost_irq, 1);
    tick();
    tick();

    // Different registers in the same cycle: both commit.
    applyStimulus(1, 1, 32'h22, 0, 0, 12'h781, 32'h0);
    tick();
    applyStimulus(1, 1, 32'h22, 1, 1, 12'h780, 32'h44);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    checkOutput("both_fromhost", csr_rdata, 32'h22);
    checkOutput("both_tohost", host_csr_tohost, 32'h44);
    tick();
    tick();

    // Req held for 10 cycles yields one ack; a fresh req yields another.
    applyStimulus(1, 1, 32'h0, 0, 0, 12'h781, 32'h0);
    ack_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (host_csr_ack) ack_count++;
    end
    checkOutput("hold_one_ack", ack_count, 1);
    checkOutput("hold_irq_zero", fromhost_irq, 0);
    applyStimulus(0, 1, 32'h0, 0, 0, 12'h781, 32'h0);
    tick();
    applyStimulus(1, 1, 32'h0, 0, 0, 12'h781, 32'h0);
    ack_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (host_csr_ack) ack_count++;
    end
    checkOutput("second_ack", ack_count, 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    tick();

    // Req dropped before ack: the access still completes.
    applyStimulus(1, 1, 32'h3C, 0, 0, 12'h781, 32'h0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    tick();
    checkOutput("early_drop_ack", host_csr_ack, 1);
    checkOutput("early_drop_data", csr_rdata, 32'h3C);
    tick();
    tick();
    checkOutput("early_drop_idle", host_csr_ack, 0);

    // Address miss: no hit, zero read data, no side effects.
    applyStimulus(0, 0, 32'h0, 1, 1, 12'h300, 32'hFFFF_FFFF);
    checkOutput("miss_hit", csr_hit, 0);
    checkOutput("miss_rdata", csr_rdata, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 12'h781, 32'h0);
    checkOutput("miss_tohost", host_csr_tohost, 32'h44);
    checkOutput("miss_fromhost", csr_rdata, 32'h3C);
    checkOutput("miss_irq", fromhost_irq, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
